cv32e41p_instr_class_monitor: RTL and testbench
===============================================

Name: cv32e41p_instr_class_monitor

Overview:
- Programmable retired-instruction classifier for simulation and trace. It is the runtime successor to the fixed opcode mask/match constants used by the tracer.
- Each retired instruction is matched against NUM_CLASSES run-time mask/match entries. Per-class counters increment, and counters can be snapshotted for readout.
- Instructions of selected classes are pushed into an event FIFO with a valid/ready output.
- Sits beside the core, fed from the writeback/retire stage.

Parameters:
NUM_CLASSES, 8, number of mask/match entries and counters (1..32)
CNT_WIDTH, 32, width of each class counter and the miss counter
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
count_en_i  in  1  global counting enable
ret_valid_i  in  1  one instruction retires this cycle
ret_instr_i  in  32  retired instruction word (decompressed)
cfg_we_i  in  1  write class table entry
cfg_idx_i  in  $clog2(NUM_CLASSES)  entry index
cfg_mask_i  in  32  entry mask
cfg_match_i  in  32  entry match value
cfg_trace_en_i  in  1  entry pushes events to FIFO
snap_i  in  1  snapshot counters and clear live counters
rd_idx_i  in  $clog2(NUM_CLASSES)  snapshot counter select
rd_cnt_o  out  CNT_WIDTH  snapshot counter rd_idx_i (combinational read of snapshot regs)
rd_miss_o  out  CNT_WIDTH  snapshot of the no-match counter
evt_valid_o  out  1  FIFO head valid
evt_ready_i  in  1  consumer accepts head
evt_class_o  out  $clog2(NUM_CLASSES)  class index of head
evt_instr_o  out  32  instruction word of head
evt_overflow_o  out  1  sticky: an event was dropped because the FIFO was full
evt_clr_i  in  1  flush FIFO and clear overflow

Behaviour:
- Reset (rst_i high, async) sets every class to mask=0, match=32'hFFFF_FFFF and trace_en=0, so no class can match.
- Reset also clears all live counters, snapshot registers, the miss counter and the FIFO. Outputs after reset: rd_cnt_o=0, rd_miss_o=0, evt_valid_o=0, evt_class_o=0, evt_instr_o=0, evt_overflow_o=0.
- Match rule: entry k hits when (ret_instr_i & mask[k]) == match[k]. The lowest hitting index wins (priority encode), and exactly one counter increments per retire.
- Counting: when ret_valid_i & count_en_i:
  - on a hit, live[k] increments;
  - on no hit, the miss counter increments.
  - Counters update on the next clock edge.
- Saturation: with SATURATE=1, a counter at all-ones holds. With SATURATE=0 it wraps to 0.
- Class table writes (cfg_we_i) take effect from the next cycle. A retire in the same cycle as a write uses the old entry.
- Snapshot: on snap_i, snap[k] <= live[k] (including any same-cycle increment) and the miss snapshot is taken likewise.
  - Live counters are cleared in the same edge.
  - A retire coincident with snap_i is counted in the snapshot, not in the new interval.
- Event push condition: ret_valid_i & count_en_i & hit & trace_en[k]. The push writes {k, ret_instr_i} at the tail. Events have no meaning for the miss class.
- FIFO:
  - Pop when evt_valid_o & evt_ready_i.
  - Head is visible 1 cycle after push into an empty FIFO (registered storage; no bypass).
  - Simultaneous push and pop when full is accepted; occupancy is unchanged.
  - Push when full with no pop: the event is dropped and evt_overflow_o is set (sticky).
  - Pointer width is $clog2(FIFO_DEPTH)+1, wrapping naturally. Full when the MSBs differ and the LSBs are equal.
- evt_clr_i empties the FIFO and clears overflow. A push in the same cycle is discarded (clear wins).
- evt_class_o and evt_instr_o hold their last value while evt_valid_o=0; they are 0 after reset.
- count_en_i=0 blocks counting and event pushes. Snapshot, config and pop still operate.
- Reset mid-operation clears the FIFO contents, pending events and counters immediately, without waiting for a clock edge.

Test Plan:
- Basic classify: cfg idx0 mask=0x0000707F, match=0x00000013 (ADDI); retire 0x00100093 ×3 and 0x00000033 ×2; snap, rd_idx=0 -> rd_cnt_o=3, rd_miss_o=2.
- Priority/overlap: idx0 mask=0x7F match=0x33 (OP), idx1 mask=0xFE00707F match=0x02004033 (DIV); retire 0x0220C0B3 -> only class0 increments; swap the entries -> class0 (DIV) counts.
- Saturation: CNT_WIDTH=4, SATURATE=1, 20 ADDI retires -> rd_cnt_o=15. With SATURATE=0 -> rd_cnt_o=4.
- FIFO overflow: FIFO_DEPTH=8, trace_en=1, evt_ready_i=0, 9 matching retires -> 8 entries, evt_overflow_o=1. Drain: instr words come out in order and evt_valid_o falls after the 8th pop. evt_clr_i clears overflow.
- Snapshot collision: snap_i coincident with an ADDI retire while live=5 -> snapshot=6, live=0. A subsequent retire -> live=1.
- Async reset mid-burst: assert rst_i between edges with the FIFO holding 3 entries -> evt_valid_o=0 and all counters 0 immediately. A post-reset retire of 0x00100093 counts as a miss, because reset clears the table.

Source files
------------

// File: rtl/cv32e41p_instr_class_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cv32e41p_instr_class_monitor
// Brief    : Run-time mask/match classifier for retired instructions with
//            per-class counters, snapshot readout and a traced-event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e41p_instr_class_monitor #(
    parameter int NUM_CLASSES = 8,
    parameter int CNT_WIDTH   = 32,
    parameter bit SATURATE    = 1'b1,
    parameter int FIFO_DEPTH  = 8,
    localparam int c_idx_w    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 count_en_i,
    input  logic                 ret_valid_i,
    input  logic [31:0]          ret_instr_i,
    input  logic                 cfg_we_i,
    input  logic [c_idx_w-1:0]   cfg_idx_i,
    input  logic [31:0]          cfg_mask_i,
    input  logic [31:0]          cfg_match_i,
    input  logic                 cfg_trace_en_i,
    input  logic                 snap_i,
    input  logic [c_idx_w-1:0]   rd_idx_i,
    output logic [CNT_WIDTH-1:0] rd_cnt_o,
    output logic [CNT_WIDTH-1:0] rd_miss_o,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [c_idx_w-1:0]   evt_class_o,
    output logic [31:0]          evt_instr_o,
    output logic                 evt_overflow_o,
    input  logic                 evt_clr_i
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam int c_ew = c_idx_w + 32;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    // ------------------------------------------------------------------------
    // Class table
    // ------------------------------------------------------------------------
    logic [31:0]            r_mask  [NUM_CLASSES];
    logic [31:0]            r_match [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] r_trace_en;

    // Reset value mask=0/match=all-ones can never hit, so an unconfigured
    // entry is inert.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_mask[k]  <= '0;
                r_match[k] <= '1;
            end
            r_trace_en <= '0;
        end else if (cfg_we_i && (32'(cfg_idx_i) < NUM_CLASSES)) begin
            r_mask[cfg_idx_i]     <= cfg_mask_i;
            r_match[cfg_idx_i]    <= cfg_match_i;
            r_trace_en[cfg_idx_i] <= cfg_trace_en_i;
        end
    end

    // ------------------------------------------------------------------------
    // Priority classifier: lowest hitting index wins
    // ------------------------------------------------------------------------
    logic               w_hit;
    logic [c_idx_w-1:0] w_hit_idx;
    logic               w_count;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
            if ((ret_instr_i & r_mask[k]) == r_match[k]) begin
                w_hit     = 1'b1;
                w_hit_idx = c_idx_w'(k);
            end
        end
    end

    assign w_count = ret_valid_i & count_en_i;

    // ------------------------------------------------------------------------
    // Live counters and snapshots
    // ------------------------------------------------------------------------
    function automatic logic [CNT_WIDTH-1:0] f_inc(input logic [CNT_WIDTH-1:0] v);
        if (SATURATE && (v == c_cnt_max)) begin
            return v;
        end
        return v + CNT_WIDTH'(1);
    endfunction

    logic [CNT_WIDTH-1:0] r_live     [NUM_CLASSES];
    logic [CNT_WIDTH-1:0] r_snap     [NUM_CLASSES];
    logic [CNT_WIDTH-1:0] r_miss;
    logic [CNT_WIDTH-1:0] r_snap_miss;
    logic [CNT_WIDTH-1:0] w_live_nxt [NUM_CLASSES];
    logic [CNT_WIDTH-1:0] w_miss_nxt;

    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
            w_live_nxt[k] = r_live[k];
            if (w_count && w_hit && (w_hit_idx == c_idx_w'(k))) begin
                w_live_nxt[k] = f_inc(r_live[k]);
            end
        end
        w_miss_nxt = r_miss;
        if (w_count && !w_hit) begin
            w_miss_nxt = f_inc(r_miss);
        end
    end

    // A retire coincident with a snapshot lands in the snapshot, so the
    // snapshot samples the next-state values rather than the registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_live[k] <= '0;
                r_snap[k] <= '0;
            end
            r_miss      <= '0;
            r_snap_miss <= '0;
        end else if (snap_i) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_snap[k] <= w_live_nxt[k];
                r_live[k] <= '0;
            end
            r_snap_miss <= w_miss_nxt;
            r_miss      <= '0;
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_live[k] <= w_live_nxt[k];
            end
            r_miss <= w_miss_nxt;
        end
    end

    assign rd_cnt_o  = (32'(rd_idx_i) < NUM_CLASSES) ? r_snap[rd_idx_i] : '0;
    assign rd_miss_o = r_snap_miss;

    // ------------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------------
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_ew-1:0] r_mem [FIFO_DEPTH];
    logic [c_ew-1:0] r_hold;
    logic            r_overflow;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_ew-1:0] w_head;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                        (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push_req = w_count & w_hit & r_trace_en[w_hit_idx];
    assign w_pop      = !w_empty & evt_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign w_push     = w_push_req & (!w_full | w_pop);
    assign w_drop     = w_push_req & w_full & !w_pop;
    assign w_head     = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (evt_clr_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !evt_clr_i) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {w_hit_idx, ret_instr_i};
        end
    end

    // Remembers the last visible head so the event outputs stay put when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold <= '0;
        end else if (!w_empty) begin
            r_hold <= w_head;
        end
    end

    assign evt_valid_o                = !w_empty;
    assign {evt_class_o, evt_instr_o} = w_empty ? r_hold : w_head;
    assign evt_overflow_o             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cv32e41p_instr_class_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e41p_instr_class_monitor
// Brief    : Directed self-checking bench; three instances share stimulus
//            (default, 4-bit saturating, 4-bit wrapping counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e41p_instr_class_monitor;

    localparam logic [31:0] c_addi   = 32'h0010_0093;
    localparam logic [31:0] c_add    = 32'h0000_0033;
    localparam logic [31:0] c_div    = 32'h0220_C0B3;
    localparam logic [31:0] c_m_addi = 32'h0000_707F;
    localparam logic [31:0] c_v_addi = 32'h0000_0013;
    localparam logic [31:0] c_m_op   = 32'h0000_007F;
    localparam logic [31:0] c_v_op   = 32'h0000_0033;
    localparam logic [31:0] c_m_div  = 32'hFE00_707F;
    localparam logic [31:0] c_v_div  = 32'h0200_4033;

    logic        clk = 1'b0;
    logic        rst, count_en, ret_valid, cfg_we, cfg_trace_en, snap;
    logic        evt_ready, evt_clr;
    logic [31:0] ret_instr, cfg_mask, cfg_match;
    logic [2:0]  cfg_idx, rd_idx;

    logic [31:0] rd_cnt, rd_miss, evt_instr;
    logic        evt_valid, evt_overflow;
    logic [2:0]  evt_class;

    logic [3:0]  s_rd_cnt, s_rd_miss, w_rd_cnt, w_rd_miss;
    logic        s_evt_valid, s_evt_overflow, w_evt_valid, w_evt_overflow;
    logic [2:0]  s_evt_class, w_evt_class;
    logic [31:0] s_evt_instr, w_evt_instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e41p_instr_class_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .count_en_i(count_en), .ret_valid_i(ret_valid),
        .ret_instr_i(ret_instr), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match), .cfg_trace_en_i(cfg_trace_en),
        .snap_i(snap), .rd_idx_i(rd_idx), .rd_cnt_o(rd_cnt), .rd_miss_o(rd_miss),
        .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_class_o(evt_class),
        .evt_instr_o(evt_instr), .evt_overflow_o(evt_overflow), .evt_clr_i(evt_clr)
    );

    cv32e41p_instr_class_monitor #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .count_en_i(count_en), .ret_valid_i(ret_valid),
        .ret_instr_i(ret_instr), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match), .cfg_trace_en_i(cfg_trace_en),
        .snap_i(snap), .rd_idx_i(rd_idx), .rd_cnt_o(s_rd_cnt), .rd_miss_o(s_rd_miss),
        .evt_valid_o(s_evt_valid), .evt_ready_i(evt_ready), .evt_class_o(s_evt_class),
        .evt_instr_o(s_evt_instr), .evt_overflow_o(s_evt_overflow), .evt_clr_i(evt_clr)
    );

    cv32e41p_instr_class_monitor #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst), .count_en_i(count_en), .ret_valid_i(ret_valid),
        .ret_instr_i(ret_instr), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
        .cfg_mask_i(cfg_mask), .cfg_match_i(cfg_match), .cfg_trace_en_i(cfg_trace_en),
        .snap_i(snap), .rd_idx_i(rd_idx), .rd_cnt_o(w_rd_cnt), .rd_miss_o(w_rd_miss),
        .evt_valid_o(w_evt_valid), .evt_ready_i(evt_ready), .evt_class_o(w_evt_class),
        .evt_instr_o(w_evt_instr), .evt_overflow_o(w_evt_overflow), .evt_clr_i(evt_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [31:0] m, input logic [31:0] v,
                       input logic te);
        cfg_we = 1'b1; cfg_idx = idx; cfg_mask = m; cfg_match = v; cfg_trace_en = te;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic retire(input logic [31:0] instr, input int n);
        ret_valid = 1'b1;
        ret_instr = instr;
        repeat (n) tick();
        ret_valid = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    initial begin
        rst = 1'b0; count_en = 1'b1; ret_valid = 1'b0; ret_instr = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_match = '0; cfg_trace_en = 1'b0;
        snap = 1'b0; rd_idx = '0; evt_ready = 1'b0; evt_clr = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset_rd_cnt", 64'(rd_cnt), 64'h0);
        check("reset_rd_miss", 64'(rd_miss), 64'h0);
        check("reset_evt", 64'({evt_valid, evt_class, evt_instr, evt_overflow}), 64'h0);
        check("reset_small", 64'({s_rd_cnt, s_rd_miss, s_evt_valid, s_evt_overflow,
                                  w_rd_cnt, w_rd_miss, w_evt_valid, w_evt_overflow}), 64'h0);
        repeat (2) tick();
        rst = 1'b0;

        // Basic classify
        cfg(3'd0, c_m_addi, c_v_addi, 1'b0);
        retire(c_addi, 3);
        retire(c_add, 2);
        do_snap();
        check("basic_cnt0", 64'(rd_cnt), 64'd3);
        check("basic_miss", 64'(rd_miss), 64'd2);
        rd_idx = 3'd1;
        #1 check("basic_cnt1", 64'(rd_cnt), 64'd0);

        // Priority / overlap
        cfg(3'd0, c_m_op, c_v_op, 1'b0);
        cfg(3'd1, c_m_div, c_v_div, 1'b0);
        retire(c_div, 1);
        retire(c_add, 1);
        do_snap();
        rd_idx = 3'd0;
        #1 check("prio_cnt0", 64'(rd_cnt), 64'd2);
        rd_idx = 3'd1;
        #1 check("prio_cnt1", 64'(rd_cnt), 64'd0);
        check("prio_miss", 64'(rd_miss), 64'd0);
        cfg(3'd0, c_m_div, c_v_div, 1'b0);
        cfg(3'd1, c_m_op, c_v_op, 1'b0);
        retire(c_div, 1);
        retire(c_add, 1);
        do_snap();
        rd_idx = 3'd0;
        #1 check("swap_cnt0", 64'(rd_cnt), 64'd1);
        rd_idx = 3'd1;
        #1 check("swap_cnt1", 64'(rd_cnt), 64'd1);

        // Saturation vs wrap on 4-bit counters
        cfg(3'd0, c_m_addi, c_v_addi, 1'b0);
        retire(c_addi, 20);
        do_snap();
        rd_idx = 3'd0;
        #1;
        check("sat_main", 64'(rd_cnt), 64'd20);
        check("sat_4bit", 64'(s_rd_cnt), 64'd15);
        check("wrap_4bit", 64'(w_rd_cnt), 64'd4);

        // FIFO overflow and drain, traced on class 2
        cfg(3'd0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        cfg(3'd2, c_m_addi, c_v_addi, 1'b1);
        evt_ready = 1'b0;
        ret_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            ret_instr = (32'(i) << 20) | 32'h93;
            tick();
        end
        ret_valid = 1'b0;
        check("ovf_flag", 64'(evt_overflow), 64'd1);
        check("ovf_flag_small", 64'({s_evt_overflow, w_evt_overflow}), 64'h3);
        check("ovf_valid", 64'(evt_valid), 64'd1);
        check("ovf_class", 64'(evt_class), 64'd2);
        evt_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 64'(evt_valid), 64'd1);
            check("drain_instr", 64'(evt_instr), 64'((32'(i) << 20) | 32'h93));
            tick();
        end
        evt_ready = 1'b0;
        check("drain_empty", 64'(evt_valid), 64'd0);
        check("drain_hold", 64'({evt_class, evt_instr}), 64'({3'd2, 32'h0080_0093}));
        check("ovf_sticky", 64'(evt_overflow), 64'd1);
        evt_clr = 1'b1;
        tick();
        evt_clr = 1'b0;
        check("ovf_cleared", 64'(evt_overflow), 64'd0);

        // Snapshot coincident with a retire
        cfg(3'd2, c_m_addi, c_v_addi, 1'b0);
        do_snap();
        retire(c_addi, 5);
        ret_valid = 1'b1; ret_instr = c_addi; snap = 1'b1;
        tick();
        ret_valid = 1'b0; snap = 1'b0;
        rd_idx = 3'd2;
        #1;
        check("collide_snap", 64'(rd_cnt), 64'd6);
        check("collide_miss", 64'(rd_miss), 64'd0);
        retire(c_addi, 1);
        do_snap();
        check("collide_live", 64'(rd_cnt), 64'd1);

        // Asynchronous reset with 3 queued events
        cfg(3'd2, c_m_addi, c_v_addi, 1'b1);
        retire(c_addi, 3);
        retire(32'hFFFF_FFFF, 1);
        do_snap();
        check("pre_rst_valid", 64'(evt_valid), 64'd1);
        check("pre_rst_cnt", 64'(rd_cnt), 64'd3);
        check("pre_rst_miss", 64'(rd_miss), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(evt_valid), 64'd0);
        check("arst_cnt", 64'(rd_cnt), 64'd0);
        check("arst_miss", 64'(rd_miss), 64'd0);
        check("arst_evt_out", 64'({evt_class, evt_instr, evt_overflow}), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        retire(c_addi, 1);
        do_snap();
        check("post_rst_miss", 64'(rd_miss), 64'd1);
        check("post_rst_cnt2", 64'(rd_cnt), 64'd0);
        check("post_rst_valid", 64'(evt_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
